ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction register.
- Holds the PC and runs a request/ready handshake with instruction memory.
- On each fetch it presents the returned 16-bit word on Instruction and pulses IREnable, which drive the IR's Instruction and enable inputs.
- Fetches are launched by the control unit via fetch_start; the PC is loaded (branch/jump) via pc_load.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- PC_INC, 2, PC increment per completed fetch (byte-addressed 16-bit words).
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before abort (only with IFETCH_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  control request to fetch at the current PC; sampled in IDLE only.
- pc_load  in  1  load PC from pc_load_val; honoured in IDLE only.
- pc_load_val  in  16  new PC value.
- mem_ready  in  1  memory asserts when mem_rdata is valid for the current request.
- mem_rdata  in  16  instruction word from memory.
- mem_req  out  1  memory read request, held until accepted.
- mem_addr  out  16  read address, stable while mem_req=1.
- PC  out  16  current program counter.
- Instruction  out  16  last fetched word, to IR Instruction input.
- IREnable  out  1  one-cycle pulse, to IR enable.
- fetch_done  out  1  one-cycle pulse marking fetch completion.
- fetch_error  out  1  sticky abort flag (timeout build only; else tied 0).

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - state=IDLE, PC=RESET_PC, mem_req=0, mem_addr=0, Instruction=0.
  - IREnable=0, fetch_done=0, fetch_error=0, timeout counter=0.
  - An in-flight request is dropped; a mem_ready arriving after reset is ignored.
- States, encoded 2 bits: IDLE=0, WAIT=1, DONE=2; code 3 is unreachable and recovers to IDLE.
- IDLE:
  - mem_req=0.
  - pc_load=1: PC<=pc_load_val, stay in IDLE. pc_load has priority; a simultaneous fetch_start is ignored that cycle.
  - else fetch_start=1: mem_addr<=PC, mem_req<=1, fetch_error<=0, counter<=0, go to WAIT.
- WAIT:
  - mem_req=1 and mem_addr held.
  - mem_ready=1 at an edge:
    - Instruction<=mem_rdata.
    - PC<=PC+PC_INC, modulo 2^16 (16'hFFFE+2 -> 16'h0000).
    - mem_req<=0, IREnable<=1, fetch_done<=1, go to DONE.
  - pc_load and fetch_start are ignored in WAIT.
- DONE:
  - IREnable and fetch_done are high for exactly this one cycle, then cleared; go to IDLE.
  - pc_load and fetch_start are ignored in DONE.
- Latency: if mem_ready is already high in the first WAIT cycle, IREnable is high 2 cycles after the fetch_start edge. Minimum fetch-to-fetch spacing is 3 cycles.
- Instruction changes only on an accepted response. Between fetches it holds, so the IR sees a stable value.
- mem_rdata is don't-care whenever mem_ready=0 or state≠WAIT.

Optional Feature:
- Macro IFETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each WAIT cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES-1 with mem_ready still 0: mem_req<=0, fetch_error<=1, PC unchanged, no IREnable or fetch_done, go to IDLE.
  - mem_ready on that same edge wins: normal completion, no error.
  - fetch_error stays high until the next accepted fetch_start or reset.
- Undefined: no counter; WAIT lasts indefinitely; fetch_error is constant 0.

Test Plan:
- Reset then fetch_start with mem_ready=1 and mem_rdata=16'hB00F -> IREnable pulse 2 cycles later, Instruction=16'hB00F, PC=16'h0002, fetch_done for one cycle.
- pc_load_val=16'h0040 with pc_load=1 in IDLE, then fetch with mem_ready delayed 3 cycles and mem_rdata=16'h383A -> mem_addr=16'h0040 held for 4 cycles, Instruction=16'h383A, PC=16'h0042.
- pc_load and fetch_start asserted together in IDLE with pc_load_val=16'h0100 -> PC=16'h0100, no mem_req that cycle.
- PC loaded to 16'hFFFE, then one fetch -> PC wraps to 16'h0000; pc_load pulsed during WAIT is ignored.
- Reset_n dropped during WAIT, then mem_ready=1 with mem_rdata=16'hFFFF -> mem_req=0 immediately, PC=RESET_PC, Instruction stays 0, no IREnable.
- IFETCH_TIMEOUT_EN defined, mem_ready held at 0 -> mem_req drops after 16 WAIT cycles, fetch_error=1, PC unchanged; next fetch_start clears fetch_error.

Source files
------------

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage that sits directly upstream of the instruction
// register. It holds the PC and runs a request/ready handshake with
// instruction memory. Each completed fetch presents the returned word on
// Instruction and pulses IREnable (and fetch_done) for one cycle.
//
// Ports:
//   CLK          in   system clock, all state updates on the rising edge
//   Reset_n      in   asynchronous active-low reset
//   fetch_start  in   start a fetch at the current PC (sampled in IDLE only)
//   pc_load      in   load PC from pc_load_val (honoured in IDLE only)
//   pc_load_val  in   new PC value
//   mem_ready    in   memory response valid for the outstanding request
//   mem_rdata    in   instruction word from memory
//   mem_req      out  memory read request, held until accepted
//   mem_addr     out  read address, stable while mem_req is high
//   PC           out  current program counter
//   Instruction  out  last fetched word (IR Instruction input)
//   IREnable     out  one-cycle pulse (IR enable)
//   fetch_done   out  one-cycle pulse marking fetch completion
//   fetch_error  out  sticky abort flag (timeout build only, else 0)
//
// Build option:
//   IFETCH_TIMEOUT_EN  when defined, a WAIT that sees no mem_ready for
//                      TIMEOUT_CYCLES cycles is aborted and fetch_error set.
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [15:0] PC_INC         = 16'd2,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] PC,
    output logic [15:0] Instruction,
    output logic        IREnable,
    output logic        fetch_done,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic        ire_q, ire_d;
    logic        done_q, done_d;

`ifdef IFETCH_TIMEOUT_EN
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            mem_req_q <= 1'b0;
            addr_q    <= 16'h0000;
            instr_q   <= 16'h0000;
            ire_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            ire_q     <= ire_d;
            done_q    <= done_d;
`ifdef IFETCH_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        // Pulses default low so they last exactly one cycle.
        ire_d     = 1'b0;
        done_d    = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                mem_req_d = 1'b0;
                // pc_load wins over a simultaneous fetch_start.
                if (pc_load) begin
                    pc_d = pc_load_val;
                end else if (fetch_start) begin
                    addr_d    = pc_q;
                    mem_req_d = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                    err_d     = 1'b0;
                    cnt_d     = 8'd0;
`endif
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    instr_d   = mem_rdata;
                    pc_d      = pc_q + PC_INC;   // wraps modulo 2^16
                    mem_req_d = 1'b0;
                    ire_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
`ifdef IFETCH_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: PC is left untouched so the fetch can be retried.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            S_DONE: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                // Unreachable encoding: fall back to a clean idle.
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign IREnable    = ire_q;
    assign fetch_done  = done_q;

`ifdef IFETCH_TIMEOUT_EN
    assign fetch_error = err_q;
`else
    // Timeout logic absent: the abort flag can never be raised.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign fetch_error        = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        fetch_start;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] PC;
    logic [15:0] Instruction;
    logic        IREnable;
    logic        fetch_done;
    logic        fetch_error;

    ifetch_unit dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .PC          (PC),
        .Instruction (Instruction),
        .IREnable    (IREnable),
        .fetch_done  (fetch_done),
        .fetch_error (fetch_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] model_pc;     // architectural PC the model expects
    logic [15:0] model_instr;  // last word the IR should hold

    function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: every IR enable / done pulse must match the oldest expected fetch.
    always @(negedge CLK) begin
        if (IREnable === 1'b1 || fetch_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_pulse: IREnable=%b fetch_done=%b with no fetch outstanding (t=%0t)",
                         IREnable, fetch_done, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_irenable",   16'(IREnable),   16'h0001);
                chk("pulse_fetch_done", 16'(fetch_done), 16'h0001);
                chk("pulse_instr",      Instruction,     e.instr);
                chk("pulse_pc",         PC,              e.pc);
            end
        end
    end

    task automatic idle_inputs();
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        mem_ready   = 1'b0;
        mem_rdata   = 16'h0000;
    endtask

    // Load PC in IDLE, optionally with fetch_start raised in the same cycle.
    task automatic do_load(input logic [15:0] val, input logic with_fs);
        @(negedge CLK);
        pc_load     = 1'b1;
        pc_load_val = val;
        fetch_start = with_fs;
        @(negedge CLK);
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        model_pc    = val;
        chk("load_pc", PC, val);
        chk("load_no_req", 16'(mem_req), 16'h0000);
    endtask

    // One fetch; memory answers after `delay` WAIT cycles. Random pc_load /
    // fetch_start noise is injected during WAIT and DONE and must be ignored.
    task automatic do_fetch(input logic [15:0] data, input int delay);
        logic [15:0] addr;
        addr = model_pc;
        @(negedge CLK);
        fetch_start = 1'b1;
        @(negedge CLK);
        fetch_start = 1'b0;
        chk("fetch_err_clear", 16'(fetch_error), 16'h0000);
        for (int i = 0; i <= delay; i++) begin
            chk("wait_req",  16'(mem_req), 16'h0001);
            chk("wait_addr", mem_addr, addr);
            pc_load     = 1'($urandom_range(0, 1));
            pc_load_val = 16'($urandom);
            fetch_start = 1'($urandom_range(0, 1));
            if (i == delay) begin
                mem_ready = 1'b1;
                mem_rdata = data;
                model_pc    = model_pc + 16'd2;
                model_instr = data;
                exp_q.push_back('{instr: data, pc: model_pc});
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
            end
            @(negedge CLK);
        end
        // DONE cycle: noise on the control inputs must not matter.
        mem_ready   = 1'($urandom_range(0, 1));
        mem_rdata   = 16'($urandom);
        pc_load     = 1'($urandom_range(0, 1));
        pc_load_val = 16'($urandom);
        fetch_start = 1'b0;
        chk("done_req_low", 16'(mem_req), 16'h0000);
        @(negedge CLK);
        idle_inputs();
        chk("idle_instr", Instruction, model_instr);
        chk("idle_pc",    PC,          model_pc);
        chk("idle_req",   16'(mem_req), 16'h0000);
    endtask

    initial begin
        idle_inputs();
        model_pc    = 16'h0000;
        model_instr = 16'h0000;
        Reset_n     = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_mem_req",     16'(mem_req),     16'h0000);
        chk("rst_mem_addr",    mem_addr,         16'h0000);
        chk("rst_pc",          PC,               16'h0000);
        chk("rst_instr",       Instruction,      16'h0000);
        chk("rst_irenable",    16'(IREnable),    16'h0000);
        chk("rst_fetch_done",  16'(fetch_done),  16'h0000);
        chk("rst_fetch_error", 16'(fetch_error), 16'h0000);
        Reset_n = 1'b1;

        // Directed cases.
        do_fetch(16'hB00F, 0);
        do_load(16'h0040, 1'b0);
        do_fetch(16'h383A, 3);
        do_load(16'h0100, 1'b1);
        do_load(16'hFFFE, 1'b0);
        do_fetch(16'h1234, 2);
        chk("wrap_pc", PC, 16'h0000);

        // Reset in the middle of a fetch; late mem_ready must be ignored.
        do_load(16'h0200, 1'b0);
        @(negedge CLK);
        fetch_start = 1'b1;
        @(negedge CLK);
        fetch_start = 1'b0;
        chk("pre_rst_req", 16'(mem_req), 16'h0001);
        @(negedge CLK);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_req",   16'(mem_req),  16'h0000);
        chk("arst_pc",    PC,            16'h0000);
        chk("arst_instr", Instruction,   16'h0000);
        chk("arst_ire",   16'(IREnable), 16'h0000);
        mem_ready = 1'b1;
        mem_rdata = 16'hFFFF;
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (2) @(negedge CLK);
        mem_ready   = 1'b0;
        model_pc    = 16'h0000;
        model_instr = 16'h0000;
        chk("post_rst_instr", Instruction,  16'h0000);
        chk("post_rst_pc",    PC,           16'h0000);
        chk("post_rst_req",   16'(mem_req), 16'h0000);

        // Randomized mix of loads and fetches.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_load(16'($urandom), 1'($urandom_range(0, 1)));
            else
                do_fetch(16'($urandom), int'($urandom_range(0, 5)));
        end

`ifdef IFETCH_TIMEOUT_EN
        begin
            int n_wait;
            logic [15:0] pc_before;
            pc_before = model_pc;
            @(negedge CLK);
            fetch_start = 1'b1;
            @(negedge CLK);
            fetch_start = 1'b0;
            n_wait = 0;
            while (mem_req === 1'b1 && n_wait < 40) begin
                @(negedge CLK);
                n_wait++;
            end
            chk("timeout_wait_cycles", 16'(n_wait), 16'd16);
            chk("timeout_error", 16'(fetch_error), 16'h0001);
            chk("timeout_pc",    PC, pc_before);
            do_fetch(16'hCAFE, 1);
        end
`else
        // Without the timeout a very slow memory is simply waited for.
        do_fetch(16'h5A5A, 25);
        chk("no_timeout_error", 16'(fetch_error), 16'h0000);
`endif

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
